multi_sonar_ranger: RTL and testbench
=====================================

MULTI_SONAR_RANGER -- requirements
Module: multi_sonar_ranger

Interface
REQ-001 Parameter NUM_CH, default 4: number of ultrasonic sensor channels, range 1..16.
REQ-002 Parameter TRIG_CYCLES, default 500: trigger pulse width in clk cycles (10 us at 50 MHz).
REQ-003 Parameter PERIOD_CYCLES, default 12_500_000: measurement-start tick period in clk cycles.
REQ-004 Parameter TIMEOUT_CYCLES, default 1_250_000: maximum cycles allowed in WAIT_ECHO, and separately in COUNT.
REQ-005 Parameter K_Q24, default 5704: cm-per-cycle scale in unsigned Q0.24 (0.00034 cm/cycle at 50 MHz).
REQ-006 Parameter DIST_W, default 8: distance output width.
REQ-007 Local CH_W = max(1, clog2(NUM_CH)); RAW_W = 22.
REQ-008 Clocking and reset: reset rst, synchronous, active-high; clock clk.
REQ-009 clk  in  1  system clock.
REQ-010 rst  in  1  synchronous active-high reset.
REQ-011 enable  in  1  period timer runs while high.
REQ-012 ch_mask  in  NUM_CH  per-channel enable; bit i=0 skips channel i.
REQ-013 echo  in  NUM_CH  asynchronous sensor echo inputs.
REQ-014 trig  out  NUM_CH  sensor trigger outputs, registered.
REQ-015 dist_valid  out  1  result available.
REQ-016 dist_ready  in  1  consumer accepts result.
REQ-017 dist_cm  out  DIST_W  distance in cm, saturated.
REQ-018 dist_ch  out  CH_W  channel the result belongs to.
REQ-019 dist_timeout  out  1  result is a timeout, not a measurement.
REQ-020 busy  out  1  high in every state except IDLE.

Function
REQ-021 Each echo bit SHALL pass through a 2-flop synchroniser before any use.
REQ-022 While enable=1, the period counter SHALL count 0..PERIOD_CYCLES-1 and wrap, producing a one-cycle tick at the value PERIOD_CYCLES-1.
REQ-023 While enable=0, the period counter SHALL hold its value and produce no tick.
REQ-024 A tick SHALL set a one-deep pending flag; a tick arriving while the flag is already set SHALL be dropped.
REQ-025 States: IDLE, TRIG, WAIT_ECHO, COUNT, CALC, REPORT.
REQ-026 In IDLE, when pending=1 and ch_mask!=0, the FSM SHALL clear pending, select the next enabled channel and enter TRIG.
REQ-027 The next enabled channel is the first channel at or after the round-robin pointer, in ascending order with wrap from NUM_CH-1 to 0, whose ch_mask bit is 1.
REQ-028 After each selection, the pointer SHALL advance to the selected channel + 1, wrapping to 0.
REQ-029 In IDLE with ch_mask=0, pending SHALL remain set and no measurement SHALL start.
REQ-030 In TRIG, trig[sel] SHALL be high for exactly TRIG_CYCLES cycles and all other trig bits low; the FSM SHALL then enter WAIT_ECHO.
REQ-031 In WAIT_ECHO, synchronised echo[sel]=1 SHALL move the FSM to COUNT.
REQ-032 In WAIT_ECHO, TIMEOUT_CYCLES cycles without echo[sel]=1 SHALL move the FSM to REPORT with dist_timeout=1 and dist_cm all ones.
REQ-033 In COUNT, the raw counter SHALL increment once per cycle that synchronised echo[sel] is high, saturating at 2^RAW_W-1; the measured count SHALL equal the echo pulse width in cycles.
REQ-034 In COUNT, the falling edge of echo[sel] SHALL move the FSM to CALC.
REQ-035 In COUNT, TIMEOUT_CYCLES cycles with echo still high SHALL move the FSM to REPORT with dist_timeout=1 and dist_cm all ones.
REQ-036 CALC SHALL last one cycle and compute cm = (raw * K_Q24) >> 24 at full width (RAW_W+24 bits).
REQ-037 If cm > 2^DIST_W-1, dist_cm SHALL saturate to 2^DIST_W-1; dist_timeout SHALL be 0 for every CALC result.
REQ-038 In REPORT, dist_valid=1 and dist_cm, dist_ch, dist_timeout SHALL be held stable until the cycle in which dist_ready=1.
REQ-039 In the cycle dist_valid && dist_ready, the FSM SHALL return to IDLE, and dist_valid SHALL be 0 in the next cycle.
REQ-040 Echo activity on any non-selected channel SHALL be ignored.
REQ-041 Changes to ch_mask SHALL take effect only at the next selection.
REQ-042 Deasserting enable mid-measurement SHALL NOT abort the measurement in progress.

Reset
REQ-043 On rst=1 at a clk edge:
- FSM to IDLE.
- Pointer, period counter, pending flag, raw counter and timeout counter all cleared.
- trig=0, dist_valid=0, dist_cm=0, dist_ch=0, dist_timeout=0, busy=0.
- Applies in any state, including mid-TRIG (trig low the following cycle).

Verification
Bench parameters: NUM_CH=4, TRIG_CYCLES=5, PERIOD_CYCLES=100, TIMEOUT_CYCLES=5000, K_Q24=1677722, DIST_W=8.
REQ-044 enable=1, ch_mask=4'b1111, echo[0] high for 1000 cycles after trigger -> trig[0] high exactly 5 cycles; result dist_cm=100, dist_ch=0, dist_timeout=0; dist_valid held until dist_ready.
REQ-045 echo[1] high for 3000 cycles -> dist_cm=255 (saturated), dist_timeout=0.
REQ-046 echo[2] never rises -> REPORT 5000 cycles after WAIT_ECHO entry, dist_timeout=1, dist_cm=255, dist_ch=2; echo[2] stuck high -> timeout after 5000 cycles in COUNT.
REQ-047 ch_mask=4'b1010, four measurements -> dist_ch sequence 1,3,1,3; ch_mask=0 -> no trig pulses, busy stays 0.
REQ-048 dist_ready=0 for 1000 cycles -> outputs stable throughout; exactly one extra tick retained (pending), later ticks dropped.
REQ-049 rst asserted during TRIG and during REPORT -> all outputs 0 the next cycle; the next measurement starts at channel 0.

Source files
------------

// File: rtl/multi_sonar_ranger.sv
// Round-robin ultrasonic ranger: periodic trigger, echo pulse timing,
// cm conversion with saturation and a valid/ready result port.
module multi_sonar_ranger #(
    parameter int NUM_CH         = 4,
    parameter int TRIG_CYCLES    = 500,
    parameter int PERIOD_CYCLES  = 12_500_000,
    parameter int TIMEOUT_CYCLES = 1_250_000,
    parameter int K_Q24          = 5704,
    parameter int DIST_W         = 8,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NUM_CH-1:0] ch_mask,
    input  logic [NUM_CH-1:0] echo,
    output logic [NUM_CH-1:0] trig,
    output logic              dist_valid,
    input  logic              dist_ready,
    output logic [DIST_W-1:0] dist_cm,
    output logic [CH_W-1:0]   dist_ch,
    output logic              dist_timeout,
    output logic              busy
);

    localparam int RAW_W   = 22;
    localparam int PROD_W  = RAW_W + 24;
    localparam int PER_W   = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam int CNT_MAX = (TRIG_CYCLES > TIMEOUT_CYCLES) ? TRIG_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_TRIG, S_WAIT, S_COUNT, S_CALC, S_REPORT
    } state_e;

    state_e              state_q, state_d;
    logic [NUM_CH-1:0]   echo_m_q, echo_s_q;
    logic [NUM_CH-1:0]   trig_q, trig_d;
    logic [PER_W-1:0]    per_q, per_d;
    logic                pend_q, pend_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [CH_W-1:0]     sel_q, sel_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [CNT_W-1:0]    cyc_q, cyc_d;
    logic [RAW_W-1:0]    raw_q, raw_d;
    logic [DIST_W-1:0]   cm_q, cm_d;
    logic                to_q, to_d;
    logic                tick, echo_sel, found;
    logic [CH_W-1:0]     nxt;
    logic [RAW_W-1:0]    cm_full;

    function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int k);
        int v;
        v = int'(base) + k;
        if (v >= NUM_CH) v = v - NUM_CH;
        return CH_W'(v);
    endfunction

    assign tick     = enable && (per_q == PER_W'(PERIOD_CYCLES - 1));
    assign echo_sel = echo_s_q[sel_q];
    assign cm_full  = RAW_W'((PROD_W'(raw_q) * PROD_W'(K_Q24)) >> 24);

    // Scan downwards so the last hit is the closest channel at/after ptr
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (ch_mask[rr_idx(ptr_q, k)]) begin
                nxt   = rr_idx(ptr_q, k);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        per_d   = per_q;
        pend_d  = pend_q | tick;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        ch_d    = ch_q;
        cyc_d   = cyc_q;
        raw_d   = raw_q;
        cm_d    = cm_q;
        to_d    = to_q;
        trig_d  = trig_q;

        if (enable) per_d = tick ? '0 : per_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (pend_q && found) begin
                    pend_d  = tick;
                    sel_d   = nxt;
                    ptr_d   = rr_idx(nxt, 1);
                    trig_d  = NUM_CH'(1) << nxt;
                    cyc_d   = '0;
                    state_d = S_TRIG;
                end
            end
            S_TRIG: begin
                if (cyc_q == CNT_W'(TRIG_CYCLES - 1)) begin
                    trig_d  = '0;
                    cyc_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (echo_sel) begin
                    raw_d   = RAW_W'(1);
                    cyc_d   = '0;
                    state_d = S_COUNT;
                end else if (cyc_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    cm_d    = '1;
                    to_d    = 1'b1;
                    ch_d    = sel_q;
                    state_d = S_REPORT;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                end
            end
            S_COUNT: begin
                if (!echo_sel) begin
                    state_d = S_CALC;
                end else if (cyc_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    cm_d    = '1;
                    to_d    = 1'b1;
                    ch_d    = sel_q;
                    state_d = S_REPORT;
                end else begin
                    cyc_d = cyc_q + 1'b1;
                    if (raw_q != '1) raw_d = raw_q + 1'b1;
                end
            end
            S_CALC: begin
                if (cm_full > RAW_W'({DIST_W{1'b1}})) cm_d = '1;
                else cm_d = cm_full[DIST_W-1:0];
                to_d    = 1'b0;
                ch_d    = sel_q;
                state_d = S_REPORT;
            end
            S_REPORT: begin
                if (dist_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            echo_m_q <= '0;
            echo_s_q <= '0;
            trig_q   <= '0;
            per_q    <= '0;
            pend_q   <= 1'b0;
            ptr_q    <= '0;
            sel_q    <= '0;
            ch_q     <= '0;
            cyc_q    <= '0;
            raw_q    <= '0;
            cm_q     <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            echo_m_q <= echo;
            echo_s_q <= echo_m_q;
            trig_q   <= trig_d;
            per_q    <= per_d;
            pend_q   <= pend_d;
            ptr_q    <= ptr_d;
            sel_q    <= sel_d;
            ch_q     <= ch_d;
            cyc_q    <= cyc_d;
            raw_q    <= raw_d;
            cm_q     <= cm_d;
            to_q     <= to_d;
        end
    end

    assign trig         = trig_q;
    assign dist_valid   = (state_q == S_REPORT);
    assign dist_cm      = cm_q;
    assign dist_ch      = ch_q;
    assign dist_timeout = to_q;
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_multi_sonar_ranger.sv
// Randomized bench for multi_sonar_ranger with a transaction-level
// model: round-robin pointer, tick/pending bookkeeping, cm arithmetic.
module tb_multi_sonar_ranger;

    localparam int NUM_CH = 4;
    localparam int TRIG   = 5;
    localparam int PER    = 100;
    localparam int TMO    = 5000;
    localparam int K      = 1677722;
    localparam int DW     = 8;

    logic              clk = 1'b0;
    logic              rst, enable, dist_ready;
    logic [NUM_CH-1:0] ch_mask, echo, trig;
    logic              dist_valid, dist_timeout, busy;
    logic [DW-1:0]     dist_cm;
    logic [1:0]        dist_ch;

    multi_sonar_ranger #(
        .NUM_CH(NUM_CH), .TRIG_CYCLES(TRIG), .PERIOD_CYCLES(PER),
        .TIMEOUT_CYCLES(TMO), .K_Q24(K), .DIST_W(DW)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .ch_mask(ch_mask),
        .echo(echo), .trig(trig), .dist_valid(dist_valid),
        .dist_ready(dist_ready), .dist_cm(dist_cm), .dist_ch(dist_ch),
        .dist_timeout(dist_timeout), .busy(busy)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;
    int m_ptr = 0;
    int ticks = 0;
    int pc = 0;
    int m_tk_take = 0;
    bit drop_en = 0;
    bit mon_on = 0;

    // Period timer as the requirement states it: tick every PER enabled cycles
    always @(posedge clk) begin
        if (rst) pc <= 0;
        else if (enable) begin
            if (pc == PER - 1) begin
                pc <= 0;
                ticks <= ticks + 1;
            end else pc <= pc + 1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_cm(input int w);
        longint p;
        p = (longint'(w) * longint'(K)) >>> 24;
        return (p > 255) ? 255 : int'(p);
    endfunction

    function automatic int next_ch();
        for (int k = 0; k < NUM_CH; k++)
            if (ch_mask[(m_ptr + k) % NUM_CH]) return (m_ptr + k) % NUM_CH;
        return -1;
    endfunction

    function automatic logic [NUM_CH-1:0] noise(input int c, input bit v);
        logic [NUM_CH-1:0] r;
        r = NUM_CH'($urandom);
        r[c] = v;
        return r;
    endfunction

    // Per-cycle checks: trigger exclusivity and result hold/release
    logic pv, pr, prst, pto;
    logic [DW-1:0] pcm;
    logic [1:0] pch;
    always @(negedge clk) begin
        #1;
        if (mon_on) begin
            nvec++;
            if ($countones(trig) > 1 || (dist_valid && trig != '0)) begin
                nerr++;
                $display("FAIL trig_excl: trig=%b valid=%b", trig, dist_valid);
            end
            if (pv && !prst) begin
                nvec++;
                if (!pr) begin
                    if ({dist_valid, dist_cm, dist_ch, dist_timeout} !== {1'b1, pcm, pch, pto}) begin
                        nerr++;
                        $display("FAIL hold: got v%b cm%0d ch%0d to%b expected v1 cm%0d ch%0d to%b",
                                 dist_valid, dist_cm, dist_ch, dist_timeout, pcm, pch, pto);
                    end
                end else if (dist_valid !== 1'b0) begin
                    nerr++;
                    $display("FAIL release: valid got %b expected 0", dist_valid);
                end
            end
        end
        pv   <= dist_valid;
        pr   <= dist_ready;
        prst <= rst;
        pcm  <= dist_cm;
        pch  <= dist_ch;
        pto  <= dist_timeout;
    end

    task automatic wait_trig(output int lat, output int c);
        int n;
        n = 0;
        c = -1;
        while (trig == '0 && n < 400) begin
            m_tk_take = ticks;
            @(negedge clk);
            n++;
        end
        lat = n;
        nvec++;
        if (trig == '0) begin
            nerr++;
            $display("FAIL start_wait: got no trigger in %0d cycles expected one", n);
        end else begin
            for (int i = 0; i < NUM_CH; i++) if (trig[i]) c = i;
        end
    endtask

    task automatic measure(input int w, input int dly, input int hold, input bit stuck,
                           input int lit_ch, output int lat,
                           output logic [DW-1:0] got_cm, output logic got_to);
        int c, e, n, k, ecm;
        bit eto;
        got_cm = '0;
        got_to = 1'b0;
        wait_trig(lat, c);
        if (c < 0) return;
        e = next_ch();
        chk("sel_ch", 64'(c), 64'(e));
        if (lit_ch >= 0) chk("sel_ch_lit", 64'(c), 64'(lit_ch));
        if (e >= 0) m_ptr = (e + 1) % NUM_CH;
        n = 0;
        while (trig[c] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("trig_width", 64'(n), 64'(TRIG));
        if (drop_en) enable = 1'b0;
        k = 0;
        if (w == 0 && !stuck) begin
            while (!dist_valid && k < TMO + 100) begin
                echo = noise(c, 1'b0);
                @(negedge clk);
                k++;
            end
            chk("wait_tmo_lat", 64'(k), 64'(TMO));
            ecm = 255;
            eto = 1'b1;
        end else begin
            repeat (dly) begin
                echo = noise(c, 1'b0);
                @(negedge clk);
            end
            if (stuck) begin
                while (!dist_valid && k < TMO + 100) begin
                    echo = noise(c, 1'b1);
                    @(negedge clk);
                    k++;
                end
                chk("count_tmo_lat", 64'(k), 64'(TMO + 3));
                ecm = 255;
                eto = 1'b1;
            end else begin
                repeat (w) begin
                    echo = noise(c, 1'b1);
                    @(negedge clk);
                end
                echo = noise(c, 1'b0);
                while (!dist_valid && k < 20) begin
                    @(negedge clk);
                    echo = noise(c, 1'b0);
                    k++;
                end
                ecm = exp_cm(w);
                eto = 1'b0;
            end
        end
        echo = '0;
        chk("valid", 64'(dist_valid), 64'(1));
        chk("dist_ch", 64'(dist_ch), 64'(e));
        chk("dist_cm", 64'(dist_cm), 64'(ecm));
        chk("dist_to", 64'(dist_timeout), 64'(eto));
        got_cm = dist_cm;
        got_to = dist_timeout;
        if (hold >= 0) begin
            repeat (hold) @(negedge clk);
            dist_ready = 1'b1;
            @(negedge clk);
            dist_ready = 1'b0;
            chk("valid_drop", 64'(dist_valid), 64'(0));
        end
    endtask

    task automatic pulse_rst_check(input string tag);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk({tag, "_trig"}, 64'(trig), 64'(0));
        chk({tag, "_valid"}, 64'(dist_valid), 64'(0));
        chk({tag, "_outs"}, 64'({dist_cm, dist_ch, dist_timeout}), 64'(0));
        chk({tag, "_busy"}, 64'(busy), 64'(0));
        m_ptr = 0;
    endtask

    initial begin
        #900_000;
        nerr++;
        $display("FAIL watchdog: simulation ran past its cycle budget");
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        int lat, c, tb, exp_lat;
        logic [DW-1:0] cm;
        logic to;
        bit pend;

        rst = 1'b1;
        enable = 1'b0;
        ch_mask = '0;
        echo = '0;
        dist_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_trig", 64'(trig), 64'(0));
        chk("rst_valid", 64'(dist_valid), 64'(0));
        chk("rst_cm", 64'(dist_cm), 64'(0));
        chk("rst_ch", 64'(dist_ch), 64'(0));
        chk("rst_to", 64'(dist_timeout), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        rst = 1'b0;
        mon_on = 1'b1;
        enable = 1'b1;
        ch_mask = 4'b1111;

        measure(1000, 7, 20, 1'b0, 0, lat, cm, to);
        chk("lit_cm_1000", 64'(cm), 64'(100));
        measure(3000, 4, 3, 1'b0, 1, lat, cm, to);
        chk("lit_cm_sat", 64'(cm), 64'(255));
        measure(0, 0, 2, 1'b0, 2, lat, cm, to);
        chk("lit_wait_tmo", 64'({cm, to}), 64'({8'd255, 1'b1}));
        ch_mask = 4'b0100;
        measure(0, 9, 2, 1'b1, 2, lat, cm, to);
        chk("lit_count_tmo", 64'({cm, to}), 64'({8'd255, 1'b1}));

        ch_mask = 4'b1111;
        measure(20, 3, 1000, 1'b0, -1, lat, cm, to);
        measure(15, 2, 0, 1'b0, -1, lat, cm, to);
        chk("pending_kept_lat", 64'(lat), 64'(1));
        tb = m_tk_take;
        exp_lat = (ticks > tb) ? 1 : (PER + 1 - pc);
        measure(12, 1, 0, 1'b0, -1, lat, cm, to);
        chk("tick_drop_lat", 64'(lat), 64'(exp_lat));

        wait_trig(lat, c);
        @(negedge clk);
        pulse_rst_check("rst_in_trig");
        measure(40, 2, 1, 1'b0, 0, lat, cm, to);
        measure(30, 2, -1, 1'b0, -1, lat, cm, to);
        @(negedge clk);
        pulse_rst_check("rst_in_report");

        ch_mask = 4'b1010;
        measure(25, 1, 0, 1'b0, 1, lat, cm, to);
        measure(25, 1, 0, 1'b0, 3, lat, cm, to);
        measure(25, 1, 0, 1'b0, 1, lat, cm, to);
        measure(25, 1, 0, 1'b0, 3, lat, cm, to);
        ch_mask = '0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            chk("mask0_idle", 64'({trig, busy}), 64'(0));
        end
        ch_mask = 4'b1111;
        measure(50, 3, 1, 1'b0, -1, lat, cm, to);
        chk("mask0_pend_lat", 64'(lat), 64'(1));

        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 2) == 0) ch_mask = NUM_CH'($urandom_range(1, 15));
            measure($urandom_range(1, 2700), $urandom_range(0, 40),
                    $urandom_range(0, 8), 1'b0, -1, lat, cm, to);
        end

        ch_mask = 4'b1111;
        drop_en = 1'b1;
        measure(200, 5, 2, 1'b0, -1, lat, cm, to);
        drop_en = 1'b0;
        pend = (ticks > m_tk_take);
        if (pend) begin
            measure(10, 1, 0, 1'b0, -1, lat, cm, to);
            chk("dis_pend_lat", 64'(lat), 64'(1));
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            chk("disabled_idle", 64'({trig, busy}), 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
